// File: rtl/euler_pkg.sv
// Shared Euler definitions: update-stage state encoding, signed limits and the
// signed-overflow detect reused by every Euler adder.
package euler_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_ADD  = ADD,
    ST_WB   = WB
  } upd_state_t;

  // Limits are built 64 bits wide; callers size-cast to their DATA_SIZE.
  function automatic logic [63:0] smax(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] smin(input int width);
    return 64'd1 << (width - 1);
  endfunction

  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/euler_update_stage_if.sv
// Bus between the multiplier stage / controller and the Euler update stage.
// start_upd/done_upd: start is sampled only while busy is low; done_upd is a
// one-cycle pulse, and a new start is accepted in that same cycle.
interface euler_update_stage_if #(
  parameter int DATA_SIZE = 32,
  parameter int N_VARS    = 4,
  parameter int IDX_W     = $clog2(N_VARS)
);
  logic                 start_upd;
  logic [IDX_W-1:0]     idx;
  logic [DATA_SIZE-1:0] delta;
  logic                 ovf_in;
  logic                 load_en;
  logic [IDX_W-1:0]     load_idx;
  logic [DATA_SIZE-1:0] load_data;
  logic [IDX_W-1:0]     rd_idx;
  logic                 clr_ovf;
  logic [DATA_SIZE-1:0] rd_data;
  logic                 busy;
  logic                 done_upd;
  logic [DATA_SIZE-1:0] out;
  logic                 overflow_flag;
  logic                 idx_err;
  logic [1:0]           dbg_state;

  modport master (
    output start_upd, idx, delta, ovf_in, load_en, load_idx, load_data, rd_idx, clr_ovf,
    input  rd_data, busy, done_upd, out, overflow_flag, idx_err, dbg_state
  );

  modport slave (
    input  start_upd, idx, delta, ovf_in, load_en, load_idx, load_data, rd_idx, clr_ovf,
    output rd_data, busy, done_upd, out, overflow_flag, idx_err, dbg_state
  );
endinterface

// File: rtl/euler_update_stage_sat_adder.sv
// Combinational signed adder with overflow detect; clamps to the signed
// limits when EULER_UPD_SATURATE_EN is defined, otherwise wraps.
module sat_adder
  import euler_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  output logic [DATA_SIZE-1:0] sum,
  output logic                 ovf
);
`ifdef EULER_UPD_SATURATE_EN
  localparam logic [DATA_SIZE-1:0] SMAX = DATA_SIZE'(smax(DATA_SIZE));
  localparam logic [DATA_SIZE-1:0] SMIN = DATA_SIZE'(smin(DATA_SIZE));
`endif

  logic [DATA_SIZE-1:0] raw;

  always_comb begin
    raw = a + b;
    ovf = add_ovf(a[DATA_SIZE-1], b[DATA_SIZE-1], raw[DATA_SIZE-1]);
`ifdef EULER_UPD_SATURATE_EN
    // On overflow both operands share a's sign, so a's sign picks the limit.
    sum = ovf ? (a[DATA_SIZE-1] ? SMIN : SMAX) : raw;
`else
    sum = raw;
`endif
  end
endmodule

// File: rtl/euler_update_stage.sv
// Euler update stage: x[idx] <- x[idx] + delta over IDLE->ADD->WB, owning the
// state-variable bank. Saturation is selected by EULER_UPD_SATURATE_EN.
module euler_update_stage
  import euler_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int N_VARS    = 4,
  parameter int IDX_W     = $clog2(N_VARS)
) (
  input logic clk,
  input logic rst,
  euler_update_stage_if.slave bus
);
  upd_state_t state, state_next;

  logic [DATA_SIZE-1:0] x [N_VARS];
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_SIZE-1:0] a_q, delta_q, sum_q, a_sel, add_sum, out_q;
  logic                 ovf_in_q, ovf_q, add_ovf_w;
  logic                 done_q, idx_err_q, flag_q;

  function automatic logic in_range(input logic [IDX_W-1:0] i);
    return {1'b0, i} < (IDX_W + 1)'(N_VARS);
  endfunction

  assign a_sel        = in_range(bus.idx) ? x[bus.idx] : '0;
  assign bus.rd_data  = in_range(bus.rd_idx) ? x[bus.rd_idx] : '0;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.done_upd = done_q;
  assign bus.idx_err  = idx_err_q;
  assign bus.out      = out_q;
  assign bus.overflow_flag = flag_q;
  assign bus.dbg_state     = state;

  sat_adder #(.DATA_SIZE(DATA_SIZE)) u_add (
    .a   (a_q),
    .b   (delta_q),
    .sum (add_sum),
    .ovf (add_ovf_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.start_upd) state_next = ST_ADD;
      ST_ADD:  state_next = ST_WB;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_VARS; i++) x[i] <= '0;
      idx_q     <= '0;
      a_q       <= '0;
      delta_q   <= '0;
      sum_q     <= '0;
      ovf_in_q  <= 1'b0;
      ovf_q     <= 1'b0;
      out_q     <= '0;
      done_q    <= 1'b0;
      idx_err_q <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      idx_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A start in the same cycle as a load takes priority; the load is lost.
          if (bus.start_upd) begin
            idx_q    <= bus.idx;
            delta_q  <= bus.delta;
            ovf_in_q <= bus.ovf_in;
            a_q      <= a_sel;
          end else if (bus.load_en && in_range(bus.load_idx)) begin
            x[bus.load_idx] <= bus.load_data;
          end
        end
        ST_ADD: begin
          sum_q <= add_sum;
          ovf_q <= add_ovf_w | ovf_in_q;
        end
        ST_WB: begin
          if (in_range(idx_q)) begin
            x[idx_q] <= sum_q;
            out_q    <= sum_q;
          end else begin
            idx_err_q <= 1'b1;
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
      // A completing overflow beats a coincident clear.
      if (state == ST_WB && ovf_q) flag_q <= 1'b1;
      else if (bus.clr_ovf)        flag_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_euler_update_stage.sv
// Directed bench for euler_update_stage: a 4-variable instance for the main
// datapath and a 3-variable instance for out-of-range index handling.
module tb_euler_update_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

`ifdef EULER_UPD_SATURATE_EN
  localparam logic [31:0] EXP_POS_OVF = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_NEG_OVF = 32'h8000_0000;
`else
  localparam logic [31:0] EXP_POS_OVF = 32'h8000_0010;
  localparam logic [31:0] EXP_NEG_OVF = 32'h7FFF_FFFF;
`endif

  always #5 clk = ~clk;

  euler_update_stage_if #(.DATA_SIZE(32), .N_VARS(4)) ia ();
  euler_update_stage_if #(.DATA_SIZE(32), .N_VARS(3)) ib ();

  euler_update_stage #(.DATA_SIZE(32), .N_VARS(4)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  euler_update_stage #(.DATA_SIZE(32), .N_VARS(3)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_a(input logic [1:0] i, input logic [31:0] d);
    ia.load_en = 1'b1; ia.load_idx = i; ia.load_data = d;
    @(negedge clk);
    ia.load_en = 1'b0;
  endtask

  task automatic read_a(input string tag, input logic [1:0] i, input logic [31:0] e);
    ia.rd_idx = i;
    #1;
    check(tag, ia.rd_data, e);
  endtask

  // Returns on the negedge where done_upd should be visible.
  task automatic upd_a(input logic [1:0] i, input logic [31:0] d, input logic oi, input bit hold);
    ia.start_upd = 1'b1; ia.idx = i; ia.delta = d; ia.ovf_in = oi;
    @(negedge clk);
    ia.load_en = 1'b0; ia.ovf_in = 1'b0;
    if (!hold) ia.start_upd = 1'b0;
    check("busy_in_add", ia.busy, 1);
    check("done_early1", ia.done_upd, 0);
    @(negedge clk);
    ia.start_upd = 1'b0;
    check("done_early2", ia.done_upd, 0);
    @(negedge clk);
    check("done_pulse", ia.done_upd, 1);
    check("busy_at_done", ia.busy, 0);
  endtask

  task automatic clear_ovf_a;
    ia.clr_ovf = 1'b1;
    @(negedge clk);
    ia.clr_ovf = 1'b0;
    check("flag_cleared", ia.overflow_flag, 0);
  endtask

  task automatic load_b(input logic [1:0] i, input logic [31:0] d);
    ib.load_en = 1'b1; ib.load_idx = i; ib.load_data = d;
    @(negedge clk);
    ib.load_en = 1'b0;
  endtask

  task automatic upd_b(input logic [1:0] i, input logic [31:0] d);
    ib.start_upd = 1'b1; ib.idx = i; ib.delta = d; ib.ovf_in = 1'b0;
    @(negedge clk);
    ib.start_upd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b_done", ib.done_upd, 1);
  endtask

  task automatic read_b(input string tag, input logic [1:0] i, input logic [31:0] e);
    ib.rd_idx = i;
    #1;
    check(tag, ib.rd_data, e);
  endtask

  initial begin
    ia.start_upd = 0; ia.idx = 0; ia.delta = 0; ia.ovf_in = 0; ia.load_en = 0;
    ia.load_idx = 0; ia.load_data = 0; ia.rd_idx = 0; ia.clr_ovf = 0;
    ib.start_upd = 0; ib.idx = 0; ib.delta = 0; ib.ovf_in = 0; ib.load_en = 0;
    ib.load_idx = 0; ib.load_data = 0; ib.rd_idx = 0; ib.clr_ovf = 0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_busy", ia.busy, 0);
    check("rst_done", ia.done_upd, 0);
    check("rst_out", ia.out, 0);
    check("rst_flag", ia.overflow_flag, 0);
    check("rst_idx_err", ia.idx_err, 0);
    check("rst_state", ia.dbg_state, 0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) read_a("rst_x", 2'(i), 32'd0);

    // Initial conditions
    load_a(2'd0, 32'd10);
    load_a(2'd1, -32'sd5);
    load_a(2'd2, 32'd0);
    load_a(2'd3, 32'd7);
    read_a("ld_x0", 2'd0, 32'd10);
    read_a("ld_x1", 2'd1, 32'hFFFF_FFFB);
    read_a("ld_x2", 2'd2, 32'd0);
    read_a("ld_x3", 2'd3, 32'd7);
    check("ld_busy", ia.busy, 0);

    // Basic update with start held one extra cycle while busy
    upd_a(2'd1, 32'd20, 1'b0, 1'b1);
    check("upd1_out", ia.out, 32'd15);
    check("upd1_flag", ia.overflow_flag, 0);
    check("upd1_idx_err", ia.idx_err, 0);
    read_a("upd1_x1", 2'd1, 32'd15);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("no_extra_done", ia.done_upd, 0);
    end
    read_a("upd1_x1_hold", 2'd1, 32'd15);

    // Positive overflow
    load_a(2'd2, 32'h7FFF_FFF0);
    upd_a(2'd2, 32'h20, 1'b0, 1'b0);
    check("povf_flag", ia.overflow_flag, 1);
    check("povf_out", ia.out, EXP_POS_OVF);
    read_a("povf_x2", 2'd2, EXP_POS_OVF);
    @(negedge clk);
    check("flag_sticky", ia.overflow_flag, 1);
    clear_ovf_a();

    // Upstream overflow only flags, never alters data
    upd_a(2'd0, 32'd1, 1'b1, 1'b0);
    read_a("ovfin_x0", 2'd0, 32'd11);
    check("ovfin_flag", ia.overflow_flag, 1);
    clear_ovf_a();

    // Negative overflow
    load_a(2'd3, 32'h8000_0000);
    upd_a(2'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("novf_flag", ia.overflow_flag, 1);
    read_a("novf_x3", 2'd3, EXP_NEG_OVF);
    clear_ovf_a();

    // Signed add crossing zero, no overflow
    upd_a(2'd1, 32'hFFFF_FFEC, 1'b0, 1'b0);
    check("neg_out", ia.out, 32'hFFFF_FFFB);
    check("neg_flag", ia.overflow_flag, 0);

    // Clear held through a completing overflow: set wins
    ia.clr_ovf = 1'b1;
    upd_a(2'd0, 32'd0, 1'b1, 1'b0);
    ia.clr_ovf = 1'b0;
    check("set_wins", ia.overflow_flag, 1);
    clear_ovf_a();

    // Load while busy is dropped
    ia.start_upd = 1'b1; ia.idx = 2'd3; ia.delta = 32'd0; ia.ovf_in = 1'b0;
    @(negedge clk);
    ia.start_upd = 1'b0;
    ia.load_en = 1'b1; ia.load_idx = 2'd0; ia.load_data = 32'd99;
    @(negedge clk);
    ia.load_en = 1'b0;
    @(negedge clk);
    check("busy_ld_done", ia.done_upd, 1);
    read_a("busy_ld_x0", 2'd0, 32'd11);

    // Start and load together: only the update happens
    ia.load_en = 1'b1; ia.load_idx = 2'd0; ia.load_data = 32'd500;
    upd_a(2'd0, 32'd1, 1'b0, 1'b0);
    read_a("start_wins_x0", 2'd0, 32'd12);

    // Reset during ADD aborts the update
    ia.start_upd = 1'b1; ia.idx = 2'd1; ia.delta = 32'd5;
    @(negedge clk);
    ia.start_upd = 1'b0;
    check("pre_rst_busy", ia.busy, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", ia.busy, 0);
    for (int i = 0; i < 4; i++) read_a("mid_rst_x", 2'(i), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_rst_no_done", ia.done_upd, 0);
    end
    check("mid_rst_out", ia.out, 0);

    // Out-of-range index on a 3-variable bank
    load_b(2'd0, 32'd1);
    load_b(2'd1, 32'd2);
    load_b(2'd2, 32'd3);
    load_b(2'd3, 32'd77);
    read_b("b_rd_oor", 2'd3, 32'd0);
    upd_b(2'd1, 32'd4);
    check("b_out", ib.out, 32'd6);
    check("b_idx_err_ok", ib.idx_err, 0);
    upd_b(2'd3, 32'd5);
    check("b_idx_err", ib.idx_err, 1);
    check("b_out_held", ib.out, 32'd6);
    @(negedge clk);
    check("b_idx_err_pulse", ib.idx_err, 0);
    read_b("b_x0", 2'd0, 32'd1);
    read_b("b_x1", 2'd1, 32'd6);
    read_b("b_x2", 2'd2, 32'd3);
    read_b("b_rd_oor2", 2'd3, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
